// File: rtl/rd_pntrs_and_empty.sv
// Read-side pointer stage of the dual-clock FIFO.
// Brings the write-side Gray pointer into the read clock domain. Holds the
// binary/Gray read pointer and produces the registered empty flag, the word
// count and the underflow pulse. The Gray read pointer goes back to the write
// side, and the binary LSBs address the RAM read port.
module rd_pntrs_and_empty #(
    parameter int AWIDTH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              rd_clk_i,
    input  logic              srst_i,
    input  logic              rd_req_i,
    input  logic [AWIDTH:0]   wr_pntr_gray_i,
    output logic [AWIDTH-1:0] rd_pntr_o,
    output logic [AWIDTH:0]   rd_pntr_gray_wr_o,
    output logic              rd_empty_o,
    output logic [AWIDTH:0]   rd_usedw_o,
    output logic              rd_underflow_o
);

    typedef logic [AWIDTH:0] ptr_t;

    // Gray-to-binary conversion: bit i is the XOR of Gray bits AWIDTH..i.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int i = AWIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    ptr_t sync_q [SYNC_STAGES];
    ptr_t wr_gray_s;
    ptr_t wr_bin_s;

    ptr_t rd_bin_q,  rd_bin_d;
    ptr_t rd_gray_q, rd_gray_d;
    ptr_t usedw_q,   usedw_d;
    logic empty_q,     empty_d;
    logic underflow_q, underflow_d;
    logic rd_ack;

    // Write-pointer synchroniser. Only this chain touches the asynchronous input.
    always_ff @(posedge rd_clk_i) begin
        // NOTE: the chain is a handful of flops rather than a RAM, so it can be
        // cleared on reset. Every sequential assignment here uses <= so that
        // each stage samples the previous stage's old value.
        if (srst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_pntr_gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wr_gray_s = sync_q[SYNC_STAGES-1];
    assign wr_bin_s  = gray2bin(wr_gray_s);

    // Next-state logic for the read pointer and the flags.
    always_comb begin
        // NOTE: every signal gets an unconditional assignment in this block,
        // so no path can leave a value held and no latch is inferred.
        rd_ack      = rd_req_i & ~empty_q;
        rd_bin_d    = rd_bin_q + {{AWIDTH{1'b0}}, rd_ack};
        rd_gray_d   = rd_bin_d ^ (rd_bin_d >> 1);
        // The flags are built from the next pointer. A read of the last word
        // therefore sets empty on the same edge that advances the pointer.
        empty_d     = (rd_gray_d == wr_gray_s);
        usedw_d     = wr_bin_s - rd_bin_d;
        underflow_d = rd_req_i & empty_q;
    end

    // Pointer and flag registers.
    always_ff @(posedge rd_clk_i) begin
        if (srst_i) begin
            rd_bin_q    <= '0;
            rd_gray_q   <= '0;
            empty_q     <= 1'b1;
            usedw_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_bin_q    <= rd_bin_d;
            rd_gray_q   <= rd_gray_d;
            empty_q     <= empty_d;
            usedw_q     <= usedw_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_pntr_o         = rd_bin_q[AWIDTH-1:0];
    assign rd_pntr_gray_wr_o = rd_gray_q;
    assign rd_empty_o        = empty_q;
    assign rd_usedw_o        = usedw_q;
    assign rd_underflow_o    = underflow_q;

endmodule
